// File: rtl/spi_reg_bridge_if.sv
// Pin and register-bus bundle for spi_reg_bridge: SPI pins toward the host MCU,
// strobe/data signals toward the pwm_controller_top register file.
`timescale 1ns/1ps
interface spi_reg_bridge_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              spi_clk_i;
    logic              spi_ncs_i;
    logic              spi_mosi_i;
    logic              spi_miso_o;
    logic [ADDR_W-1:0] reg_addr_o;
    logic [DATA_W-1:0] reg_wdata_o;
    logic              reg_wr_o;
    logic              reg_rd_o;
    logic [DATA_W-1:0] reg_rdata_i;
    logic              frame_err_o;

    modport slave (
        input  spi_clk_i, spi_ncs_i, spi_mosi_i, reg_rdata_i,
        output spi_miso_o, reg_addr_o, reg_wdata_o, reg_wr_o, reg_rd_o, frame_err_o
    );

    modport master (
        output spi_clk_i, spi_ncs_i, spi_mosi_i, reg_rdata_i,
        input  spi_miso_o, reg_addr_o, reg_wdata_o, reg_wr_o, reg_rd_o, frame_err_o
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave oversampled on clk_i; turns {rw, addr} + data-byte frames into
// single-cycle register write/read strobes with address auto-increment.
`timescale 1ns/1ps
module spi_reg_bridge #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            nrst_i,
    spi_reg_bridge_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, mosi_sync;
    logic                   sclk_s, ncs_s, mosi_s, sclk_d;
    logic                   sclk_rise, sclk_fall;
    logic                   armed_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [DATA_W-1:0]      rx_q, rx_next, tx_q;
    logic                   rw_q;
    logic [ADDR_W-1:0]      addr_q, reg_addr_q;
    logic [DATA_W-1:0]      reg_wdata_q;
    logic                   reg_wr_q, reg_rd_q, rd_p1, frame_err_q, miso_q;
    logic                   shift_en, byte_done, abort, tx_shift_en;

    // Pin synchronisers and SCLK edge detection
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sclk_sync <= '0;
            ncs_sync  <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk_i};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], bus.spi_ncs_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi_i};
            sclk_d    <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign rx_next   = {rx_q[DATA_W-2:0], mosi_s};

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // nCS high is checked first so it beats any SCLK edge seen in the same cycle
    always_comb begin
        state_d     = state_q;
        shift_en    = 1'b0;
        byte_done   = 1'b0;
        abort       = 1'b0;
        tx_shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && !ncs_s) state_d = ADDR;
            end
            ADDR, DATA: begin
                if (ncs_s) begin
                    state_d = IDLE;
                    abort   = (bit_cnt_q != '0);
                end else begin
                    if (sclk_rise) begin
                        shift_en = 1'b1;
                        if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
                            byte_done = 1'b1;
                            state_d   = DATA;
                        end
                    end
                    if (sclk_fall && state_q == DATA) tx_shift_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // armed_q blocks frame acceptance after reset until nCS has been seen high
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            rd_p1       <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            armed_q     <= armed_q | ncs_s;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            rd_p1       <= reg_rd_q;
            frame_err_q <= abort;
            if (state_q == IDLE) begin
                bit_cnt_q <= '0;
                rx_q      <= '0;
                tx_q      <= '0;
                rw_q      <= 1'b0;
                miso_q    <= 1'b0;
            end else begin
                if (shift_en) begin
                    rx_q      <= rx_next;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
                if (byte_done && state_q == ADDR) begin
                    rw_q   <= rx_next[DATA_W-1];
                    addr_q <= rx_next[ADDR_W-1:0];
                    if (rx_next[DATA_W-1]) begin
                        reg_rd_q   <= 1'b1;
                        reg_addr_q <= rx_next[ADDR_W-1:0];
                    end
                end else if (byte_done) begin
                    addr_q <= addr_q + 1'b1;
                    if (rw_q) begin
                        reg_rd_q   <= 1'b1;
                        reg_addr_q <= addr_q + 1'b1;
                    end else begin
                        reg_wr_q    <= 1'b1;
                        reg_addr_q  <= addr_q;
                        reg_wdata_q <= rx_next;
                    end
                end
                if (tx_shift_en) begin
                    miso_q <= rw_q & tx_q[DATA_W-1];
                    tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                end
                // Prefetched read data lands well before the next SCLK fall at clk_i/8
                if (rd_p1) tx_q <= bus.reg_rdata_i;
                if (ncs_s) miso_q <= 1'b0;
            end
        end
    end

    assign bus.spi_miso_o  = miso_q;
    assign bus.reg_addr_o  = reg_addr_q;
    assign bus.reg_wdata_o = reg_wdata_q;
    assign bus.reg_wr_o    = reg_wr_q;
    assign bus.reg_rd_o    = reg_rd_q;
    assign bus.frame_err_o = frame_err_q;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: directed frames plus random frames
// checked against a byte-level model of the SPI register protocol.
`timescale 1ns/1ps
module tb_spi_reg_bridge;
    localparam int HALF = 4;  // clk_i cycles per SCLK half period

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    spi_reg_bridge_if #(.ADDR_W(7), .DATA_W(8)) bus();

    spi_reg_bridge #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk_i  (clk),
        .nrst_i (nrst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem [128];
    logic [14:0] wr_obs[$], wr_exp[$];
    logic [6:0]  rd_obs[$], rd_exp[$];
    logic        miso_obs[$], miso_exp[$];
    int          err_obs, err_exp;
    int          both_obs = 0;

    logic [7:0]  frm[$];
    logic [7:0]  pbyte;
    int          pbits;

    logic        rd_pend = 1'b0;
    logic [6:0]  rd_pend_addr = '0;

    // Register-file model: answers one clk after the read strobe, noise otherwise
    always @(negedge clk) begin
        if (rd_pend) bus.reg_rdata_i = mem[rd_pend_addr];
        else         bus.reg_rdata_i = 8'($urandom);
        rd_pend      = bus.reg_rd_o;
        rd_pend_addr = bus.reg_addr_o;
    end

    always @(negedge clk) begin
        if (bus.reg_wr_o) wr_obs.push_back({bus.reg_addr_o, bus.reg_wdata_o});
        if (bus.reg_rd_o) rd_obs.push_back(bus.reg_addr_o);
        if (bus.reg_wr_o && bus.reg_rd_o) both_obs++;
        if (bus.frame_err_o) err_obs++;
    end

    task automatic clear_obs();
        wr_obs.delete();
        rd_obs.delete();
        miso_obs.delete();
        err_obs = 0;
    endtask

    task automatic spi_bit(input logic b);
        bus.spi_mosi_i = b;
        repeat (HALF) @(negedge clk);
        miso_obs.push_back(bus.spi_miso_o);
        bus.spi_clk_i = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.spi_clk_i = 1'b0;
    endtask

    task automatic send_frame(input int gap);
        logic [7:0] b;
        bus.spi_ncs_i = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < frm.size(); i++) begin
            b = frm[i];
            for (int k = 7; k >= 0; k--) spi_bit(b[k]);
        end
        for (int k = 0; k < pbits; k++) spi_bit(pbyte[7-k]);
        @(negedge clk);
        bus.spi_ncs_i = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Protocol model: byte 0 = {rw, addr}; each data byte targets addr, addr+1, ...
    function automatic void build_expected();
        logic       rw;
        logic [6:0] ad;
        logic [7:0] v;
        wr_exp.delete();
        rd_exp.delete();
        miso_exp.delete();
        err_exp = (pbits != 0) ? 1 : 0;
        if (frm.size() == 0) begin
            for (int k = 0; k < pbits; k++) miso_exp.push_back(1'b0);
            return;
        end
        v  = frm[0];
        rw = v[7];
        ad = v[6:0];
        for (int k = 0; k < 8; k++) miso_exp.push_back(1'b0);
        if (rw) rd_exp.push_back(ad);
        for (int i = 1; i < frm.size(); i++) begin
            if (rw) begin
                v = mem[ad];
                for (int k = 7; k >= 0; k--) miso_exp.push_back(v[k]);
                rd_exp.push_back(ad + 7'd1);
            end else begin
                v = frm[i];
                wr_exp.push_back({ad, v});
                for (int k = 0; k < 8; k++) miso_exp.push_back(1'b0);
            end
            ad = ad + 7'd1;
        end
        v = mem[ad];
        for (int k = 0; k < pbits; k++) miso_exp.push_back(rw ? v[7-k] : 1'b0);
    endfunction

    task automatic test_reset();
        bus.spi_ncs_i  = 1'b1;
        bus.spi_clk_i  = 1'b0;
        bus.spi_mosi_i = 1'b0;
        nrst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({bus.spi_miso_o, bus.reg_wr_o, bus.reg_rd_o, bus.frame_err_o, bus.reg_addr_o, bus.reg_wdata_o} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got miso=%b wr=%b rd=%b err=%b addr=%h wdata=%h, expected all 0",
                     bus.spi_miso_o, bus.reg_wr_o, bus.reg_rd_o, bus.frame_err_o, bus.reg_addr_o, bus.reg_wdata_o);
        end
        nrst = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({bus.reg_wr_o, bus.reg_rd_o, bus.frame_err_o, bus.spi_miso_o} !== 4'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got wr=%b rd=%b err=%b miso=%b, expected 0",
                     bus.reg_wr_o, bus.reg_rd_o, bus.frame_err_o, bus.spi_miso_o);
        end
    endtask

    task automatic test_write();
        int ones;
        clear_obs();
        frm = '{8'h01, 8'h01};
        pbits = 0;
        send_frame(10);
        n_checks++;
        if (wr_obs.size() != 1 || (wr_obs.size() == 1 && wr_obs[0] !== {7'h01, 8'h01})) begin
            n_fail++;
            $display("FAIL write_single: got %0d writes (first %h), expected 1 write {01,01}",
                     wr_obs.size(), (wr_obs.size() > 0) ? wr_obs[0] : 15'h0);
        end
        n_checks++;
        if (err_obs != 0 || rd_obs.size() != 0) begin
            n_fail++;
            $display("FAIL write_side: got err=%0d reads=%0d, expected 0 and 0", err_obs, rd_obs.size());
        end
        ones = 0;
        foreach (miso_obs[i]) if (miso_obs[i] !== 1'b0) ones++;
        n_checks++;
        if (ones != 0) begin
            n_fail++;
            $display("FAIL write_miso_low: got %0d nonzero MISO samples, expected 0", ones);
        end
    endtask

    task automatic test_read();
        logic [7:0] got;
        clear_obs();
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        frm = '{8'h80, 8'hFF};
        pbits = 0;
        send_frame(10);
        n_checks++;
        if (rd_obs.size() != 2 || (rd_obs.size() == 2 && (rd_obs[0] !== 7'h00 || rd_obs[1] !== 7'h01))) begin
            n_fail++;
            $display("FAIL read_prefetch: got %0d reads (%h,%h), expected 2 reads (00,01)", rd_obs.size(),
                     (rd_obs.size() > 0) ? rd_obs[0] : 7'h0, (rd_obs.size() > 1) ? rd_obs[1] : 7'h0);
        end
        got = 8'h00;
        for (int k = 0; k < 8; k++) got = {got[6:0], (miso_obs.size() == 16) ? miso_obs[8+k] : 1'bx};
        n_checks++;
        if (got !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_miso: got %h, expected a5", got);
        end
        n_checks++;
        if (wr_obs.size() != 0 || err_obs != 0) begin
            n_fail++;
            $display("FAIL read_side: got writes=%0d err=%0d, expected 0 and 0", wr_obs.size(), err_obs);
        end
    endtask

    task automatic test_burst_wrap();
        logic [14:0] exp [3];
        clear_obs();
        frm = '{8'h7E, 8'h11, 8'h22, 8'h33};
        pbits = 0;
        send_frame(10);
        exp[0] = {7'h7E, 8'h11};
        exp[1] = {7'h7F, 8'h22};
        exp[2] = {7'h00, 8'h33};
        n_checks++;
        if (wr_obs.size() != 3) begin
            n_fail++;
            $display("FAIL burst_count: got %0d writes, expected 3", wr_obs.size());
        end
        for (int i = 0; i < 3 && i < wr_obs.size(); i++) begin
            n_checks++;
            if (wr_obs[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL burst_write%0d: got %h, expected %h", i, wr_obs[i], exp[i]);
            end
        end
    endtask

    task automatic test_abort();
        clear_obs();
        frm = '{8'h05};
        pbyte = 8'hFF;
        pbits = 5;
        send_frame(10);
        n_checks++;
        if (wr_obs.size() != 0 || err_obs != 1) begin
            n_fail++;
            $display("FAIL abort: got writes=%0d err_pulses=%0d, expected 0 and 1", wr_obs.size(), err_obs);
        end
        clear_obs();
        frm = '{8'h05, 8'h81};
        pbits = 0;
        send_frame(10);
        n_checks++;
        if (wr_obs.size() != 1 || (wr_obs.size() == 1 && wr_obs[0] !== {7'h05, 8'h81}) || err_obs != 0) begin
            n_fail++;
            $display("FAIL abort_recover: got %0d writes (first %h) err=%0d, expected 1 write {05,81} err=0",
                     wr_obs.size(), (wr_obs.size() > 0) ? wr_obs[0] : 15'h0, err_obs);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        frm = '{8'h10, 8'h5A};
        pbits = 0;
        send_frame(1);
        frm = '{8'h11, 8'hA6};
        send_frame(10);
        n_checks++;
        if (wr_obs.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d writes, expected 2", wr_obs.size());
        end else begin
            n_checks++;
            if (wr_obs[0] !== {7'h10, 8'h5A} || wr_obs[1] !== {7'h11, 8'hA6}) begin
                n_fail++;
                $display("FAIL b2b_data: got %h,%h expected %h,%h", wr_obs[0], wr_obs[1],
                         {7'h10, 8'h5A}, {7'h11, 8'hA6});
            end
        end
        n_checks++;
        if (err_obs != 0) begin
            n_fail++;
            $display("FAIL b2b_err: got %0d error pulses, expected 0", err_obs);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] junk;
        clear_obs();
        bus.spi_ncs_i = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < 3; k++) spi_bit(1'b1);
        bus.spi_mosi_i = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.spi_clk_i = 1'b1;
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        #1;
        n_checks++;
        if ({bus.spi_miso_o, bus.reg_wr_o, bus.reg_rd_o, bus.frame_err_o, bus.reg_addr_o, bus.reg_wdata_o} !== 19'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got addr=%h wdata=%h wr=%b rd=%b err=%b, expected all 0",
                     bus.reg_addr_o, bus.reg_wdata_o, bus.reg_wr_o, bus.reg_rd_o, bus.frame_err_o);
        end
        repeat (2) @(negedge clk);
        bus.spi_clk_i = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        junk = 16'h0344;
        for (int k = 15; k >= 0; k--) spi_bit(junk[k]);
        repeat (10) @(negedge clk);
        n_checks++;
        if (wr_obs.size() != 0 || rd_obs.size() != 0 || err_obs != 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got writes=%0d reads=%0d err=%0d, expected none",
                     wr_obs.size(), rd_obs.size(), err_obs);
        end
        bus.spi_ncs_i = 1'b1;
        repeat (6) @(negedge clk);
        clear_obs();
        frm = '{8'h00, 8'h81};
        pbits = 0;
        send_frame(10);
        n_checks++;
        if (wr_obs.size() != 1 || (wr_obs.size() == 1 && wr_obs[0] !== {7'h00, 8'h81})) begin
            n_fail++;
            $display("FAIL midreset_recover: got %0d writes (first %h), expected 1 write {00,81}",
                     wr_obs.size(), (wr_obs.size() > 0) ? wr_obs[0] : 15'h0);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 24; f++) begin
            int nfull;
            int bad;
            nfull = int'($urandom_range(4, 0));
            frm.delete();
            for (int i = 0; i < nfull; i++) frm.push_back(8'($urandom));
            pbits = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 1)) : 0;
            if (nfull == 0) pbits = int'($urandom_range(7, 1));
            pbyte = 8'($urandom);
            build_expected();
            clear_obs();
            send_frame(int'($urandom_range(6, 1)));
            repeat (10) @(negedge clk);
            n_checks++;
            if (wr_obs.size() != wr_exp.size() || rd_obs.size() != rd_exp.size()) begin
                n_fail++;
                $display("FAIL rand%0d_counts: got wr=%0d rd=%0d, expected wr=%0d rd=%0d",
                         f, wr_obs.size(), rd_obs.size(), wr_exp.size(), rd_exp.size());
            end
            for (int i = 0; i < wr_exp.size() && i < wr_obs.size(); i++) begin
                n_checks++;
                if (wr_obs[i] !== wr_exp[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_wr%0d: got %h, expected %h", f, i, wr_obs[i], wr_exp[i]);
                end
            end
            for (int i = 0; i < rd_exp.size() && i < rd_obs.size(); i++) begin
                n_checks++;
                if (rd_obs[i] !== rd_exp[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_rd%0d: got %h, expected %h", f, i, rd_obs[i], rd_exp[i]);
                end
            end
            bad = (miso_obs.size() != miso_exp.size()) ? 1 : 0;
            for (int i = 0; i < miso_exp.size() && i < miso_obs.size(); i++)
                if (miso_obs[i] !== miso_exp[i]) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL rand%0d_miso: got %0d bad MISO samples of %0d, expected 0", f, bad, miso_exp.size());
            end
            n_checks++;
            if (err_obs != err_exp) begin
                n_fail++;
                $display("FAIL rand%0d_err: got %0d error pulses, expected %0d", f, err_obs, err_exp);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        bus.reg_rdata_i = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_burst_wrap();
        test_abort();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frames();
        n_checks++;
        if (both_obs != 0) begin
            n_fail++;
            $display("FAIL wr_rd_exclusive: got %0d cycles with both strobes, expected 0", both_obs);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
